imem_fetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the synchronous-read instruction memory for the pipelined core. It drives the memory byte address and tracks which request is in flight across the memory's one-cycle registered read. It presents a valid/stall-qualified instruction and PC to decode. It absorbs decode back-pressure with a one-word hold buffer, with no lost or duplicated words and no bubble on release, and handles redirects from branch/jump resolution with a fixed one-cycle refill.

---
 rtl/imem_fetch_ctrl.sv | 142 ++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller: sequences a synchronous-read instruction memory,
// presents a valid/stall-qualified instruction to decode, absorbs back-pressure
// with a one-word hold buffer and handles redirects with a one-cycle refill.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        fetch_en,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_err
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc_req;
    logic [XLEN-1:0]   r_pc_resp;
    logic [XLEN-1:0]   r_hold_instr;
    logic              r_held;
    logic              r_resp_valid;
    logic              r_fetch_err;

    state_t            w_state;
    logic [XLEN-1:0]   w_pc_req;
    logic [XLEN-1:0]   w_pc_resp;
    logic [XLEN-1:0]   w_hold_instr;
    logic              w_held;
    logic              w_resp_valid;
    logic              w_fetch_err;
    logic              w_if_valid;
    logic              w_consume;
    logic [XLEN-1:0]   w_pc_inc;

    // Next-state and datapath update; redirect beats halt beats stall beats advance.
    always_comb begin
        w_state      = r_state;
        w_pc_req     = r_pc_req;
        w_pc_resp    = r_pc_resp;
        w_hold_instr = r_hold_instr;
        w_held       = r_held;
        w_resp_valid = r_resp_valid;
        w_fetch_err  = r_fetch_err;
        w_if_valid   = (r_state == RUN) && r_resp_valid;
        w_consume    = w_if_valid && !stall;
        w_pc_inc     = r_pc_req + XLEN'(4);

        if ((r_state != ERR) && redirect_valid) begin
            w_resp_valid = 1'b0;
            w_held       = 1'b0;
            if (redirect_target[1:0] != 2'b00) begin
                // Misaligned target: lock up with pc_req frozen until reset.
                w_state     = ERR;
                w_fetch_err = 1'b1;
            end else begin
                // Pending memory response belongs to the old stream and is dropped.
                w_pc_req = redirect_target;
                w_state  = fetch_en ? FILL : IDLE;
            end
        end else begin
            unique case (r_state)
                IDLE, FILL: begin
                    if (fetch_en) begin
                        w_state      = RUN;
                        w_pc_resp    = r_pc_req;
                        w_pc_req     = w_pc_inc;
                        w_resp_valid = 1'b1;
                    end else begin
                        w_state = IDLE;
                    end
                end
                RUN: begin
                    if (!fetch_en) begin
                        w_state      = IDLE;
                        w_resp_valid = 1'b0;
                        w_held       = 1'b0;
                        // Rewind so the unconsumed word is refetched on restart.
                        if (!w_consume) begin
                            w_pc_req = r_pc_resp;
                        end
                    end else if (w_if_valid && stall) begin
                        // Memory keeps re-reading pc_req, so its word is ready on release.
                        if (!r_held) begin
                            w_hold_instr = imem_rdata;
                            w_held       = 1'b1;
                        end
                    end else begin
                        w_pc_resp    = r_pc_req;
                        w_pc_req     = w_pc_inc;
                        w_resp_valid = 1'b1;
                        w_held       = 1'b0;
                    end
                end
                default: begin
                    w_state = ERR;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_pc_req     <= RESET_PC;
            r_pc_resp    <= '0;
            r_hold_instr <= '0;
            r_held       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_fetch_err  <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_pc_req     <= w_pc_req;
            r_pc_resp    <= w_pc_resp;
            r_hold_instr <= w_hold_instr;
            r_held       <= w_held;
            r_resp_valid <= w_resp_valid;
            r_fetch_err  <= w_fetch_err;
        end
    end

    assign imem_addr = r_pc_req;
    assign if_valid  = w_if_valid;
    assign if_instr  = r_held ? r_hold_instr : imem_rdata;
    assign if_pc     = r_pc_resp;
    assign fetch_err = r_fetch_err;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a one-cycle registered-read memory model.
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        resetn;
    logic        fetch_en;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_err;

    int n_pass;
    int n_total;

    imem_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .fetch_en        (fetch_en),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .fetch_err       (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: a few program words, every other address returns itself.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0004: mem_word = 32'h00F0_0093;
            32'h0000_0008: mem_word = 32'h0020_8113;
            32'h0000_000C: mem_word = 32'h0031_0193;
            32'h0000_0014: mem_word = 32'h00C0_9183;
            32'h0000_0018: mem_word = 32'h0041_8213;
            default:       mem_word = a;
        endcase
    endfunction

    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; fetch_en = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0;
        tick(); tick();
        n_total++;
        if ({imem_addr, if_valid, if_pc, fetch_err} !== {32'h0, 1'b0, 32'h0, 1'b0})
            $display("FAIL reset_state addr=%h v=%b pc=%h err=%b want addr=0 v=0 pc=0 err=0",
                     imem_addr, if_valid, if_pc, fetch_err);
        else n_pass++;
        resetn = 1'b1;
        tick();
        n_total++;
        if ({imem_addr, if_valid} !== {32'h0, 1'b0})
            $display("FAIL idle_hold addr=%h v=%b want addr=0 v=0", imem_addr, if_valid);
        else n_pass++;
    endtask

    task automatic test_start();
        fetch_en = 1'b1;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'h0, 32'h0, 32'h4})
            $display("FAIL start_w0 v=%b pc=%h ins=%h addr=%h want 1/0/0/4",
                     if_valid, if_pc, if_instr, imem_addr);
        else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'h4, 32'h00F0_0093, 32'h8})
            $display("FAIL start_w1 v=%b pc=%h ins=%h addr=%h want 1/4/00f00093/8",
                     if_valid, if_pc, if_instr, imem_addr);
        else n_pass++;
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'h4, 32'h00F0_0093, 32'h8})
                $display("FAIL stall_hold%0d v=%b pc=%h ins=%h addr=%h want 1/4/00f00093/8",
                         i, if_valid, if_pc, if_instr, imem_addr);
            else n_pass++;
        end
        stall = 1'b0;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'h8, 32'h0020_8113, 32'hC})
            $display("FAIL stall_release v=%b pc=%h ins=%h addr=%h want 1/8/00208113/c",
                     if_valid, if_pc, if_instr, imem_addr);
        else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'hC, 32'h0031_0193})
            $display("FAIL stall_next v=%b pc=%h ins=%h want 1/c/00310193",
                     if_valid, if_pc, if_instr);
        else n_pass++;
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_target = 32'd20;
        tick();
        redirect_valid = 1'b0;
        n_total++;
        if ({if_valid, imem_addr} !== {1'b0, 32'd20})
            $display("FAIL redir_bubble v=%b addr=%h want 0/14", if_valid, imem_addr);
        else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd20, 32'h00C0_9183})
            $display("FAIL redir_target v=%b pc=%h ins=%h want 1/14/00c09183",
                     if_valid, if_pc, if_instr);
        else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'd24, 32'h0041_8213, 32'd28})
            $display("FAIL redir_next v=%b pc=%h ins=%h addr=%h want 1/18/00418213/1c",
                     if_valid, if_pc, if_instr, imem_addr);
        else n_pass++;
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'd8;
        tick();
        stall = 1'b0; redirect_valid = 1'b0;
        n_total++;
        if ({if_valid, imem_addr} !== {1'b0, 32'd8})
            $display("FAIL redir_stall_bubble v=%b addr=%h want 0/8", if_valid, imem_addr);
        else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd8, 32'h0020_8113})
            $display("FAIL redir_stall_target v=%b pc=%h ins=%h want 1/8/00208113",
                     if_valid, if_pc, if_instr);
        else n_pass++;
    endtask

    task automatic test_halt();
        stall = 1'b1;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'd8, 32'h0020_8113, 32'd12})
            $display("FAIL halt_prestall v=%b pc=%h ins=%h addr=%h want 1/8/00208113/c",
                     if_valid, if_pc, if_instr, imem_addr);
        else n_pass++;
        fetch_en = 1'b0;
        tick();
        n_total++;
        if ({if_valid, imem_addr} !== {1'b0, 32'd8})
            $display("FAIL halt_rewind v=%b addr=%h want 0/8", if_valid, imem_addr);
        else n_pass++;
        tick();
        n_total++;
        if ({if_valid, imem_addr} !== {1'b0, 32'd8})
            $display("FAIL halt_idle v=%b addr=%h want 0/8", if_valid, imem_addr);
        else n_pass++;
        fetch_en = 1'b1; stall = 1'b0;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd8, 32'h0020_8113})
            $display("FAIL halt_resume v=%b pc=%h ins=%h want 1/8/00208113",
                     if_valid, if_pc, if_instr);
        else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'd12, 32'h0031_0193, 32'd16})
            $display("FAIL halt_resume_next v=%b pc=%h ins=%h addr=%h want 1/c/00310193/10",
                     if_valid, if_pc, if_instr, imem_addr);
        else n_pass++;
        // Halt on an edge where the word is consumed: no rewind.
        fetch_en = 1'b0;
        tick();
        n_total++;
        if ({if_valid, imem_addr} !== {1'b0, 32'd16})
            $display("FAIL halt_consumed v=%b addr=%h want 0/10", if_valid, imem_addr);
        else n_pass++;
        fetch_en = 1'b1;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd16, 32'd16})
            $display("FAIL halt_consumed_resume v=%b pc=%h ins=%h want 1/10/10",
                     if_valid, if_pc, if_instr);
        else n_pass++;
    endtask

    task automatic test_fill_redirect();
        redirect_valid = 1'b1; redirect_target = 32'd20;
        tick();
        redirect_target = 32'd24;
        tick();
        redirect_valid = 1'b0;
        n_total++;
        if ({if_valid, imem_addr} !== {1'b0, 32'd24})
            $display("FAIL fill_redir_bubble v=%b addr=%h want 0/18", if_valid, imem_addr);
        else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'd24, 32'h0041_8213})
            $display("FAIL fill_redir_target v=%b pc=%h ins=%h want 1/18/00418213",
                     if_valid, if_pc, if_instr);
        else n_pass++;
    endtask

    task automatic test_misaligned();
        redirect_valid = 1'b1; redirect_target = 32'd40;
        tick();
        redirect_target = 32'h0000_0006;
        tick();
        n_total++;
        if ({fetch_err, if_valid, imem_addr} !== {1'b1, 1'b0, 32'd40})
            $display("FAIL misalign_enter err=%b v=%b addr=%h want 1/0/28",
                     fetch_err, if_valid, imem_addr);
        else n_pass++;
        redirect_target = 32'd20;
        for (int i = 0; i < 3; i++) begin
            tick();
            redirect_valid = 1'b0;
            n_total++;
            if ({fetch_err, if_valid, imem_addr} !== {1'b1, 1'b0, 32'd40})
                $display("FAIL misalign_stuck%0d err=%b v=%b addr=%h want 1/0/28",
                         i, fetch_err, if_valid, imem_addr);
            else n_pass++;
        end
        resetn = 1'b0;
        #1;
        n_total++;
        if ({fetch_err, if_valid, if_pc, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0})
            $display("FAIL misalign_reset err=%b v=%b pc=%h addr=%h want 0/0/0/0",
                     fetch_err, if_valid, if_pc, imem_addr);
        else n_pass++;
        tick();
        resetn = 1'b1;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'h0})
            $display("FAIL misalign_restart0 v=%b pc=%h ins=%h want 1/0/0",
                     if_valid, if_pc, if_instr);
        else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h4, 32'h00F0_0093})
            $display("FAIL misalign_restart1 v=%b pc=%h ins=%h want 1/4/00f00093",
                     if_valid, if_pc, if_instr);
        else n_pass++;
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0})
            $display("FAIL wrap_top v=%b pc=%h ins=%h addr=%h want 1/fffffffc/fffffffc/0",
                     if_valid, if_pc, if_instr, imem_addr);
        else n_pass++;
        tick();
        n_total++;
        if ({if_valid, if_pc, if_instr, imem_addr} !== {1'b1, 32'h0, 32'h0, 32'h4})
            $display("FAIL wrap_zero v=%b pc=%h ins=%h addr=%h want 1/0/0/4",
                     if_valid, if_pc, if_instr, imem_addr);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_start();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_halt();
        test_fill_redirect();
        test_misaligned();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Run-time guard so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
